// File: rtl/gst_snd_dma.sv
// gst_snd_dma: STE DMA sound frame registers and word-fetch sequencer feeding the shifter FIFO
module gst_snd_dma #(
    parameter int LOAD_LEN = 4
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        CS,
    input  logic [6:1]  A,
    input  logic [15:0] DIN,
    input  logic        RW,
    output logic [15:0] DOUT,
    input  logic        SLOT,
    input  logic        SREQ,
    output logic        SLOAD_N,
    output logic [23:1] sndadr,
    output logic        sint,
    output logic        frame_end
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADV} state_t;

    state_t      r_state, w_next;
    logic        r_cs_d, r_play, r_loop, r_lreq, r_fe;
    logic [23:0] r_start, r_end, r_cur, r_endl;
    logic [23:1] r_adr;
    logic [3:0]  r_cnt;
    logic        w_wr, w_rise, w_go, w_adv, w_hit, w_reload, w_latch, w_empty, w_load_done;
    logic [23:0] w_nxt;
    logic [7:0]  w_rd;

    assign w_wr        = CS & ~RW & ~r_cs_d;
    assign w_rise      = w_wr & (A == 6'd0) & DIN[0] & ~r_play;
    assign w_go        = (r_state == S_IDLE) & r_play & ~r_lreq & SREQ & SLOT;
    assign w_adv       = r_state == S_ADV;
    assign w_nxt       = r_cur + 24'd2;
    assign w_hit       = w_adv & (w_nxt == r_endl);
    assign w_reload    = w_hit & r_play & r_loop;
    assign w_latch     = r_lreq | w_reload;
    assign w_empty     = w_latch & (r_start == r_end);
    assign w_load_done = r_cnt == 4'(LOAD_LEN - 1);

    assign sndadr    = r_adr;
    assign sint      = r_play;
    assign frame_end = r_fe;
    assign DOUT      = (CS & RW) ? {8'h00, w_rd} : 16'h0000;

    // fetch sequencer state register; reset aborts any fetch in flight
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next state and fetch strobe
    always_comb begin
        w_next  = r_state;
        SLOAD_N = 1'b1;
        case (r_state)
            S_IDLE: w_next = w_go ? S_LOAD : S_IDLE;
            S_LOAD: begin
                SLOAD_N = 1'b0;
                w_next  = w_load_done ? S_ADV : S_LOAD;
            end
            S_ADV:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // strobe length counter and address capture so sndadr cannot move mid-fetch
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            r_cnt <= '0;
            r_adr <= '0;
        end else begin
            r_cnt <= (r_state == S_LOAD) ? r_cnt + 4'd1 : 4'd0;
            if (w_go) r_adr <= r_cur[23:1];
        end
    end

    // CPU registers, frame latch and counter advance; a CPU control write overrides the sequencer
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            r_cs_d  <= 1'b0;
            r_lreq  <= 1'b0;
            r_fe    <= 1'b0;
            r_play  <= 1'b0;
            r_loop  <= 1'b0;
            r_start <= '0;
            r_end   <= '0;
            r_cur   <= '0;
            r_endl  <= '0;
        end else begin
            r_cs_d <= CS;
            r_lreq <= w_rise;
            r_fe   <= w_hit | w_empty;
            if (w_adv) r_cur <= w_nxt;
            if (w_hit & ~w_reload) r_play <= 1'b0;
            if (w_latch) begin
                r_cur  <= r_start;
                r_endl <= r_end;
            end
            if (w_empty) r_play <= 1'b0;
            if (w_wr) begin
                case (A)
                    6'd0: begin
                        r_play <= DIN[0];
                        r_loop <= DIN[1];
                    end
                    6'd1:    r_start[23:16] <= DIN[7:0];
                    6'd2:    r_start[15:8]  <= DIN[7:0];
                    6'd3:    r_start[7:0]   <= {DIN[7:1], 1'b0};
                    6'd7:    r_end[23:16]   <= DIN[7:0];
                    6'd8:    r_end[15:8]    <= DIN[7:0];
                    6'd9:    r_end[7:0]     <= {DIN[7:1], 1'b0};
                    default: ;
                endcase
            end
        end
    end

    // register read mux
    always_comb begin
        w_rd = 8'h00;
        case (A)
            6'd0:    w_rd = {6'b0, r_loop, r_play};
            6'd1:    w_rd = r_start[23:16];
            6'd2:    w_rd = r_start[15:8];
            6'd3:    w_rd = {r_start[7:1], 1'b0};
            6'd4:    w_rd = r_cur[23:16];
            6'd5:    w_rd = r_cur[15:8];
            6'd6:    w_rd = {r_cur[7:1], 1'b0};
            6'd7:    w_rd = r_end[23:16];
            6'd8:    w_rd = r_end[15:8];
            6'd9:    w_rd = {r_end[7:1], 1'b0};
            default: w_rd = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_gst_snd_dma.sv
// tb_gst_snd_dma: randomized and directed checks of the sound DMA against a transaction-level model
module tb_gst_snd_dma;
    localparam int LL = 4;

    logic        clk32 = 1'b0, resb = 1'b0, CS = 1'b0, RW = 1'b1, SLOT = 1'b0, SREQ = 1'b0;
    logic [6:1]  A = '0;
    logic [15:0] DIN = '0;
    logic [15:0] DOUT;
    logic        SLOAD_N, sint, frame_end;
    logic [23:1] sndadr;

    int errors = 0, checks = 0;

    always #5 clk32 = ~clk32;

    gst_snd_dma #(.LOAD_LEN(LL)) dut (
        .clk32(clk32), .resb(resb), .CS(CS), .A(A), .DIN(DIN), .RW(RW), .DOUT(DOUT),
        .SLOT(SLOT), .SREQ(SREQ), .SLOAD_N(SLOAD_N), .sndadr(sndadr), .sint(sint),
        .frame_end(frame_end)
    );

    // observed activity, sampled on the falling edge
    int          fetch_n = 0, fe_n = 0, fe_wide = 0, adr_bad = 0, last_len = 0, run = 0;
    logic [23:1] last_adr = '0;
    bit          prev_low = 0, prev_fe = 0;

    always @(negedge clk32) begin
        if (!SLOAD_N) begin
            if (!prev_low) begin
                fetch_n++;
                last_adr = sndadr;
                run = 0;
            end else if (sndadr != last_adr) adr_bad++;
            run++;
        end else if (prev_low) last_len = run;
        if (frame_end) begin
            fe_n++;
            if (prev_fe) fe_wide++;
        end
        prev_low = !SLOAD_N;
        prev_fe  = frame_end;
    end

    // reference model: frame registers and playback at transaction level
    logic [23:0] m_start = '0, m_end = '0, m_cur = '0, m_endl = '0;
    bit          m_play = 0, m_loop = 0;
    int          e_fetch = 0, e_fe = 0;
    logic [23:1] e_adr = '0;

    function automatic void m_reset();
        m_start = '0; m_end = '0; m_cur = '0; m_endl = '0; m_play = 0; m_loop = 0;
    endfunction

    function automatic void m_wr(input logic [5:0] a, input logic [7:0] d);
        bit rise;
        case (a)
            6'd0: begin
                rise   = d[0] && !m_play;
                m_play = d[0];
                m_loop = d[1];
                if (rise) begin
                    m_cur  = m_start;
                    m_endl = m_end;
                    if (m_cur == m_endl) begin
                        m_play = 0;
                        e_fe++;
                    end
                end
            end
            6'd1: m_start[23:16] = d;
            6'd2: m_start[15:8]  = d;
            6'd3: m_start[7:0]   = d & 8'hFE;
            6'd7: m_end[23:16]   = d;
            6'd8: m_end[15:8]    = d;
            6'd9: m_end[7:0]     = d & 8'hFE;
            default: ;
        endcase
    endfunction

    function automatic void m_slot(input bit sreq);
        if (m_play && sreq) begin
            e_fetch++;
            e_adr = m_cur[23:1];
            m_cur = m_cur + 24'd2;
            if (m_cur == m_endl) begin
                e_fe++;
                if (m_loop) begin
                    m_cur  = m_start;
                    m_endl = m_end;
                    if (m_cur == m_endl) m_play = 0;
                end else m_play = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk32);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        CS = 1'b1; RW = 1'b0; A = a; DIN = {8'($urandom), d};
        cyc();
        CS = 1'b0; RW = 1'b1;
        cyc();
        cyc();
        m_wr(a, d);
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        CS = 1'b1; RW = 1'b1; A = a;
        #2;
        d = DOUT[7:0];
        chk("dout_hi", 32'(DOUT[15:8]), 32'h0);
        CS = 1'b0;
        cyc();
    endtask

    task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
        wr(6'd1, s[23:16]); wr(6'd2, s[15:8]); wr(6'd3, s[7:0]);
        wr(6'd7, e[23:16]); wr(6'd8, e[15:8]); wr(6'd9, e[7:0]);
    endtask

    task automatic slot_on(input bit sreq);
        SLOT = 1'b1; SREQ = sreq;
        m_slot(sreq);
        cyc();
        SLOT = 1'b0; SREQ = 1'($urandom);
    endtask

    task automatic settle();
        repeat (LL + 4) cyc();
    endtask

    task automatic verify();
        logic [7:0] h, m, l, c;
        rd(6'd4, h); rd(6'd5, m); rd(6'd6, l); rd(6'd0, c);
        chk("fetches", fetch_n, e_fetch);
        chk("frame_ends", fe_n, e_fe);
        chk("sint", 32'(sint), 32'(m_play));
        chk("counter", {8'h0, h, m, l}, 32'(m_cur));
        chk("ctrl", 32'(c), {30'b0, m_loop, m_play});
        chk("fe_width", fe_wide, 0);
    endtask

    task automatic slot_chk(input bit sreq);
        int f0;
        f0 = e_fetch;
        slot_on(sreq);
        settle();
        if (e_fetch != f0) begin
            chk("adr", 32'(last_adr), 32'(e_adr));
            chk("len", last_len, LL);
        end
        verify();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int f0;
        logic [7:0] d;
        logic [23:0] s;
        repeat (3) cyc();
        chk("rst_sload_n", 32'(SLOAD_N), 32'h1);
        chk("rst_sndadr", 32'(sndadr), 32'h0);
        chk("rst_sint", 32'(sint), 32'h0);
        chk("rst_frame_end", 32'(frame_end), 32'h0);
        resb = 1'b1;
        cyc();
        verify();

        // single frame, no loop
        set_frame(24'h010000, 24'h010006);
        wr(6'd0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            slot_chk(1'b1);
            chk("t1_adr", 32'(last_adr), 32'h8000 + 32'(i));
        end
        chk("t1_sint", 32'(sint), 32'h0);
        f0 = fetch_n;
        slot_chk(1'b1);
        chk("t1_no_fetch", fetch_n - f0, 0);

        // loop with start rewritten mid-frame
        set_frame(24'h010000, 24'h010006);
        wr(6'd0, 8'h03);
        slot_chk(1'b1);
        slot_chk(1'b1);
        wr(6'd1, 8'h02); wr(6'd2, 8'h00); wr(6'd3, 8'h00);
        slot_chk(1'b1);
        chk("t2_sint", 32'(sint), 32'h1);
        slot_chk(1'b1);
        chk("t2_adr", 32'(last_adr), 32'h10000);
        wr(6'd0, 8'h00);

        // back-pressure and SLOT during LOAD
        set_frame(24'h040000, 24'h040010);
        wr(6'd0, 8'h01);
        slot_chk(1'b0);
        f0 = fetch_n;
        slot_on(1'b1);
        cyc();
        SLOT = 1'b1; SREQ = 1'b1;
        cyc();
        SLOT = 1'b0;
        settle();
        chk("t3_one_pulse", fetch_n - f0, 1);
        verify();
        wr(6'd0, 8'h00);

        // empty frame, with and without loop
        set_frame(24'h030000, 24'h030000);
        f0 = fetch_n;
        wr(6'd0, 8'h01);
        verify();
        wr(6'd0, 8'h03);
        verify();
        slot_chk(1'b1);
        chk("t4_no_fetch", fetch_n - f0, 0);
        wr(6'd0, 8'h00);

        // stop during LOAD
        set_frame(24'h050000, 24'h050010);
        wr(6'd0, 8'h01);
        f0 = fetch_n;
        slot_on(1'b1);
        wr(6'd0, 8'h00);
        settle();
        chk("t5_len", last_len, LL);
        chk("t5_fetch", fetch_n - f0, 1);
        verify();
        slot_chk(1'b1);

        // readback masking and unused addresses
        wr(6'd3, 8'hFF);
        rd(6'd3, d);
        chk("lo_mask", 32'(d), 32'hFE);
        wr(6'd10, 8'hAB);
        rd(6'd10, d);
        chk("unused_a10", 32'(d), 32'h0);
        rd(6'd63, d);
        chk("unused_a63", 32'(d), 32'h0);

        // 24-bit counter wrap
        set_frame(24'hFFFFFC, 24'h000002);
        wr(6'd0, 8'h01);
        for (int i = 0; i < 3; i++) slot_chk(1'b1);
        chk("wrap_adr", 32'(last_adr), 32'h0);
        wr(6'd0, 8'h00);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    s = 24'($urandom) & 24'hFFFFFE;
                    set_frame(s, s + 24'(2 * $urandom_range(0, 4)));
                end
                2, 3: wr(6'd0, 8'($urandom_range(0, 3)));
                default: slot_chk($urandom_range(0, 3) != 0);
            endcase
        end

        // asynchronous reset mid-LOAD
        set_frame(24'h060000, 24'h060010);
        wr(6'd0, 8'h01);
        slot_on(1'b1);
        cyc();
        cyc();
        chk("t8_in_load", 32'(SLOAD_N), 32'h0);
        #2 resb = 1'b0;
        #1;
        chk("t8_sload_n", 32'(SLOAD_N), 32'h1);
        chk("t8_sndadr", 32'(sndadr), 32'h0);
        chk("t8_sint", 32'(sint), 32'h0);
        chk("t8_frame_end", 32'(frame_end), 32'h0);
        m_reset();
        cyc();
        resb = 1'b1;
        settle();
        verify();

        chk("adr_stable", adr_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gst_snd_dma.md
# gst_snd_dma

STE DMA sound address sequencer: holds the frame start/end/counter registers and play/loop control, and issues word fetches that feed the shifter's audio FIFO. Sits directly upstream of the shifter's sound engine: it reacts to the shifter's `SREQ` and drives the `SLOAD_N` strobe on which the shifter captures `MDIN` into its FIFO. It also drives the sound word address to the memory address mux.

## Interface
Parameters:
- `LOAD_LEN`, 4: number of clk32 cycles `SLOAD_N` is held low per fetch (2..15).

Ports:
- `clk32`  in  1  system clock, 32 MHz.
- `resb`  in  1  reset, asynchronous, active-low.
- `CS`  in  1  sound register select (CPU cycle to $FF8900-$FF8913).
- `A`  in  6 [6:1]  word address within the block.
- `DIN`  in  16  CPU write data; only [7:0] used.
- `RW`  in  1  1 = read, 0 = write.
- `DOUT`  out  16  register read data, [15:8] = 0.
- `SLOT`  in  1  one-cycle strobe: a sound memory slot is available.
- `SREQ`  in  1  shifter FIFO not full.
- `SLOAD_N`  out  1  fetch strobe to the shifter, active low.
- `sndadr`  out  23 [23:1]  word address of the current fetch.
- `sint`  out  1  1 while playing, 0 when stopped (to MFP GPIP7/TAI).
- `frame_end`  out  1  one-cycle pulse at each frame end.

## Operation
- Registers (byte values on DIN[7:0]/DOUT[7:0]):
  - A=0 control: [0] play, [1] loop.
  - A=1/2/3 start hi/mid/lo.
  - A=4/5/6 counter hi/mid/lo (read-only).
  - A=7/8/9 end hi/mid/lo.
  - Lo registers: bit 0 forced 0 on write and on read.
  - Other A values read 0 and ignore writes.
- Write strobe: a write is `CS & ~RW & ~CS_d`, where `CS_d` is `CS` registered one cycle. Exactly one write per CS assertion.
- Frame latch, on play 0→1 and on loop reload: `cur ← start`, `endl ← end`. Start/end writes while playing take effect only at the next latch.
- If `cur == endl` at latch (empty frame): play ← 0, pulse `frame_end`, no fetch, even when loop=1.
- FSM states:
  - IDLE → LOAD when `play & SREQ & SLOT`.
  - LOAD: `SLOAD_N` = 0 for LOAD_LEN cycles. `sndadr = cur[23:1]`, held stable through LOAD.
  - LOAD → ADV.
  - ADV (1 cycle): `cur ← cur + 2` (24-bit, wraps $FFFFFE→$000000). If `cur + 2 == endl`:
    - pulse `frame_end`;
    - if loop, frame latch;
    - else play ← 0.
  - ADV → IDLE.
- Clearing play via the CPU during LOAD: the fetch completes and `SLOAD_N` is never truncated. `cur` advances in ADV, no further fetch follows, and `cur` is retained.
- A CPU write to control in the same cycle as ADV: the CPU value wins for play/loop. The ADV address update still happens.
- `sint = play`.
- `DOUT` is combinational: register value when `CS & RW`, else 0.

## Timing
- Reset (async) values:
  - play = loop = 0; start = end = cur = endl = 0.
  - FSM = IDLE; `SLOAD_N` = 1; `sndadr` = 0; `sint` = 0; `frame_end` = 0.
  - An in-flight LOAD is aborted immediately.
- `SLOT` is sampled on cycle n. `SLOAD_N` falls at n+1 and rises at n+1+LOAD_LEN. ADV occurs on that same cycle; `cur` and `frame_end` are updated at its end.
- A `SLOT` strobe arriving outside IDLE is ignored, so at most one fetch per strobe.
- `SREQ` is sampled only on the cycle `SLOT` is high.
- Play 0→1: the frame latch happens on the cycle after the write strobe. The earliest fetch is on the next `SLOT` after that.
- `frame_end` is exactly 1 cycle wide. When loop=0 it coincides with the `sint` falling edge.

## Test plan
- Reset mid-LOAD: assert `resb`=0 while `SLOAD_N`=0 → `SLOAD_N`=1 and all outputs 0 asynchronously, with no ADV.
- Single frame, loop=0: start=$010000, end=$010006, play=1, `SREQ`=1, 3 `SLOT`s → `sndadr` = $8000, $8001, $8002. Each `SLOAD_N` low pulse lasts 4 cycles. After the third: counter=$010006, `frame_end` pulse, `sint`=0. A 4th `SLOT` gives no fetch.
- Loop: same setup with loop=1; write start=$020000 during the frame → after the 3rd fetch `cur`=$020000, `sint` stays 1, and the next fetch address is $10000.
- Back-pressure: `SREQ`=0 on a `SLOT` → no fetch and `cur` unchanged. `SLOT` during LOAD → ignored, exactly one `SLOAD_N` pulse.
- Empty frame: start=end=$030000, play=1 → `frame_end` pulse, play reads back 0, no `SLOAD_N` activity (also with loop=1).
- Stop mid-fetch and register readback: write control=0 during LOAD → the full 4-cycle pulse, counter advances by 2, then idle. A write of $FF to start lo reads back $FE; an unused A reads 0.
